// File: rtl/cv32e40p_pkg2_ft.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_pkg2_ft
// Description : Shared types and constants for the fault-tolerance status
//               supervisor of a triplicated pipeline unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_pkg2_ft;

  // Default counter width and threshold for the status supervisor
  localparam int unsigned FTSC_CNT_WIDTH     = 8;
  localparam int unsigned FTSC_IRQ_THRESHOLD = 16;

  // Health of the protected unit; only moves towards FAILED
  typedef enum logic [1:0] {
    FT_HEALTHY  = 2'd0,
    FT_DEGRADED = 2'd1,
    FT_FAILED   = 2'd2
  } ft_state_e;

  // Command opcodes accepted on the supervisor command port
  typedef enum logic [1:0] {
    FT_CMD_NOP         = 2'd0,
    FT_CMD_FORCE_BREAK = 2'd1,
    FT_CMD_CLEAR_CNT   = 2'd2,
    FT_CMD_RSVD        = 2'd3
  } ft_cmd_op_e;

  // Number of replicas flagged broken
  function automatic logic [1:0] ft_popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_ft_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ft_sat_counter
// Description : Saturating up-counter with synchronous clear. Clear wins over
//               a same-cycle increment; the count sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_ft_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Next count: clear first, otherwise increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_ft_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ft_status_ctrl
// Description : Health supervisor for one TMR-protected unit. Tracks a
//               monotonic HEALTHY/DEGRADED/FAILED state, keeps saturating
//               error statistics, raises event IRQs and serves a one-deep
//               command port able to retire a replica.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_ft_status_ctrl
  import cv32e40p_pkg2_ft::*;
#(
  parameter int unsigned CNT_WIDTH     = FTSC_CNT_WIDTH,
  parameter int unsigned IRQ_THRESHOLD = FTSC_IRQ_THRESHOLD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           is_broken_i,
  input  logic                 err_detected_i,
  input  logic                 err_corrected_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [1:0]           cmd_replica_i,
  output logic                 cmd_done_o,
  output logic                 cmd_err_o,
  output logic [2:0]           set_broken_o,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0] corr_cnt_o,
  output logic                 irq_o,
  output logic                 fatal_o
);

  // Count value one below the threshold: an increment from here hits it
  localparam logic [CNT_WIDTH-1:0] C_THR_M1 = CNT_WIDTH'(IRQ_THRESHOLD - 1);

  ft_state_e  state_q;
  ft_state_e  state_d;
  ft_cmd_op_e cmd_op;

  logic [1:0] nb_broken;
  logic       unc_err;
  logic       cmd_accept;
  logic       cnt_clr;
  logic       err_inc;
  logic       corr_inc;
  logic       thr_hit;

  logic       cmd_ready_d, cmd_ready_q;
  logic       cmd_done_d,  cmd_done_q;
  logic       cmd_err_d,   cmd_err_q;
  logic [2:0] set_broken_d, set_broken_q;
  logic       irq_d,       irq_q;
  logic       fatal_d,     fatal_q;

  logic [CNT_WIDTH-1:0] err_cnt;
  logic [CNT_WIDTH-1:0] corr_cnt;

  assign nb_broken = ft_popcount3(is_broken_i);
  assign unc_err   = err_detected_i && !err_corrected_i;
  assign cmd_op    = ft_cmd_op_e'(cmd_op_i);
  assign err_inc   = err_detected_i;
  assign corr_inc  = err_detected_i && err_corrected_i;

  // Health state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FT_HEALTHY;
    end else begin
      state_q <= state_d;
    end
  end

  // Monotonic next-state: FAILED dominates a simultaneous DEGRADED condition
  always_comb begin
    state_d = state_q;
    case (state_q)
      FT_HEALTHY: begin
        if ((nb_broken >= 2'd2) || unc_err) begin
          state_d = FT_FAILED;
        end else if (nb_broken == 2'd1) begin
          state_d = FT_DEGRADED;
        end
      end
      FT_DEGRADED: begin
        if ((nb_broken >= 2'd2) || unc_err) begin
          state_d = FT_FAILED;
        end
      end
      // FAILED is terminal; the unused encoding also falls into FAILED
      default: state_d = FT_FAILED;
    endcase
  end

  // Command decode: completes in the cycle after acceptance; a command that
  // coincides with entry into FAILED is rejected without side effects
  always_comb begin
    cmd_accept   = cmd_valid_i && cmd_ready_q;
    cmd_done_d   = cmd_accept;
    cmd_err_d    = 1'b0;
    set_broken_d = 3'b000;
    cnt_clr      = 1'b0;
    if (cmd_accept) begin
      if (state_d == FT_FAILED) begin
        cmd_err_d = 1'b1;
      end else begin
        case (cmd_op)
          FT_CMD_NOP: begin
            cmd_err_d = 1'b0;
          end
          FT_CMD_FORCE_BREAK: begin
            // Retiring a replica is only safe while all three are healthy
            if ((state_q == FT_HEALTHY) && (cmd_replica_i != 2'd3)) begin
              set_broken_d = 3'b001 << cmd_replica_i;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          FT_CMD_CLEAR_CNT: begin
            cnt_clr = 1'b1;
          end
          default: begin
            cmd_err_d = 1'b1;
          end
        endcase
      end
    end
  end

  // Threshold crossing can only happen on an increment out of THRESHOLD-1,
  // so it fires once per clear epoch since the counter never moves back
  assign thr_hit = err_inc && !cnt_clr && (err_cnt == C_THR_M1);

  // Remaining registered outputs
  always_comb begin
    cmd_ready_d = (state_d != FT_FAILED) && !cmd_accept;
    irq_d       = (state_d != state_q) || thr_hit;
    fatal_d     = (state_d == FT_FAILED);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q  <= 1'b1;
      cmd_done_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
      set_broken_q <= 3'b000;
      irq_q        <= 1'b0;
      fatal_q      <= 1'b0;
    end else begin
      cmd_ready_q  <= cmd_ready_d;
      cmd_done_q   <= cmd_done_d;
      cmd_err_q    <= cmd_err_d;
      set_broken_q <= set_broken_d;
      irq_q        <= irq_d;
      fatal_q      <= fatal_d;
    end
  end

  cv32e40p_ft_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (err_inc),
    .clr_i (cnt_clr),
    .cnt_o (err_cnt)
  );

  cv32e40p_ft_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_corr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (corr_inc),
    .clr_i (cnt_clr),
    .cnt_o (corr_cnt)
  );

  assign state_o      = state_q;
  assign err_cnt_o    = err_cnt;
  assign corr_cnt_o   = corr_cnt;
  assign cmd_ready_o  = cmd_ready_q;
  assign cmd_done_o   = cmd_done_q;
  assign cmd_err_o    = cmd_err_q;
  assign set_broken_o = set_broken_q;
  assign irq_o        = irq_q;
  assign fatal_o      = fatal_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_ft_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_ft_status_ctrl
// Description : Self-checking bench for the FT status supervisor, directed
//               scenarios plus randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_ft_status_ctrl;

  localparam int CW   = 4;
  localparam int TH   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    is_broken = 3'b000;
  logic          err_det = 1'b0;
  logic          err_corr = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [1:0]    cmd_rep = 2'd0;
  logic          cmd_ready, cmd_done, cmd_err, irq, fatal;
  logic [2:0]    set_broken;
  logic [1:0]    state;
  logic [CW-1:0] err_cnt, corr_cnt;

  always #5 clk = ~clk;

  cv32e40p_ft_status_ctrl #(
    .CNT_WIDTH     (CW),
    .IRQ_THRESHOLD (TH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .is_broken_i     (is_broken),
    .err_detected_i  (err_det),
    .err_corrected_i (err_corr),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_op_i        (cmd_op),
    .cmd_replica_i   (cmd_rep),
    .cmd_done_o      (cmd_done),
    .cmd_err_o       (cmd_err),
    .set_broken_o    (set_broken),
    .state_o         (state),
    .err_cnt_o       (err_cnt),
    .corr_cnt_o      (corr_cnt),
    .irq_o           (irq),
    .fatal_o         (fatal)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state (expected outputs after the most recent edge)
  int       m_state, m_err, m_corr;
  bit       m_ready, m_done, m_cerr, m_irq, m_fatal;
  bit [2:0] m_setb;

  logic [17:0] dut_vec;
  logic [17:0] c_reset_vec;
  assign dut_vec = {state, err_cnt, corr_cnt, cmd_ready, cmd_done, cmd_err,
                    set_broken, irq, fatal};

  function automatic logic [17:0] exp_vec();
    return {2'(m_state), 4'(m_err), 4'(m_corr), m_ready, m_done, m_cerr,
            m_setb, m_irq, m_fatal};
  endfunction

  task automatic model_reset();
    m_state = 0; m_err = 0; m_corr = 0;
    m_ready = 1'b1; m_done = 1'b0; m_cerr = 1'b0;
    m_setb = 3'b000; m_irq = 1'b0; m_fatal = 1'b0;
  endtask

  // Advance the model by one clock from the current inputs, then the DUT
  task automatic tick();
    int  nb, ns, ne, nc, rep;
    bit  acc, cerr, clr;
    bit [2:0] sb;
    nb = 0;
    for (int i = 0; i < 3; i++) nb += int'(is_broken[i]);
    if (nb >= 2 || (err_det && !err_corr)) ns = 2;
    else if (nb == 1)                      ns = 1;
    else                                   ns = 0;
    if (m_state > ns) ns = m_state;
    acc = cmd_valid && m_ready;
    rep = int'(cmd_rep);
    cerr = 1'b0; clr = 1'b0; sb = 3'b000;
    if (acc) begin
      if (ns == 2) cerr = 1'b1;
      else if (cmd_op == 2'd1) begin
        if (m_state == 0 && rep < 3) sb = 3'(1 << rep);
        else                         cerr = 1'b1;
      end
      else if (cmd_op == 2'd2) clr = 1'b1;
      else if (cmd_op == 2'd3) cerr = 1'b1;
    end
    ne = m_err + int'(err_det);
    if (ne > CMAX) ne = CMAX;
    nc = m_corr + int'(err_det && err_corr);
    if (nc > CMAX) nc = CMAX;
    if (clr) begin ne = 0; nc = 0; end
    m_irq   = (ns != m_state) || (ne == TH && m_err != TH);
    m_state = ns;
    m_err   = ne;
    m_corr  = nc;
    m_ready = (ns != 2) && !acc;
    m_done  = acc;
    m_cerr  = cerr;
    m_setb  = sb;
    m_fatal = (ns == 2);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    is_broken = 3'b000; err_det = 1'b0; err_corr = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_rep = 2'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (dut_vec !== c_reset_vec) $display("FAIL reset_values: got %h expected %h", dut_vec, c_reset_vec);
    else n_pass++;
  endtask

  task automatic test_single_break();
    do_reset();
    repeat (5) tick();
    is_broken = 3'b010;
    tick();
    n_total++;
    if (dut_vec !== exp_vec() || state !== 2'd1 || irq !== 1'b1 || fatal !== 1'b0)
      $display("FAIL single_break_edge: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
    repeat (3) begin
      tick();
      n_total++;
      if (dut_vec !== exp_vec() || irq !== 1'b0)
        $display("FAIL single_break_hold: got %h expected %h", dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_uncorrectable();
    do_reset();
    err_det = 1'b1; err_corr = 1'b0;
    tick();
    err_det = 1'b0;
    n_total++;
    if (dut_vec !== exp_vec() || state !== 2'd2 || fatal !== 1'b1 || cmd_ready !== 1'b0)
      $display("FAIL uncorrectable: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
    repeat (3) begin
      tick();
      n_total++;
      if (dut_vec !== exp_vec() || state !== 2'd2)
        $display("FAIL uncorrectable_persist: got %h expected %h", dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_force_break();
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_rep = 2'd2;
    tick();
    cmd_valid = 1'b0;
    n_total++;
    if (dut_vec !== exp_vec() || set_broken !== 3'b100 || cmd_done !== 1'b1 || cmd_err !== 1'b0)
      $display("FAIL force_break_pulse: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
    tick();
    n_total++;
    if (dut_vec !== exp_vec() || set_broken !== 3'b000 || cmd_ready !== 1'b1)
      $display("FAIL force_break_after: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
    // Breakage monitor reports the forced replica
    is_broken = 3'b100;
    tick();
    n_total++;
    if (dut_vec !== exp_vec() || state !== 2'd1)
      $display("FAIL force_break_degraded: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_rep = 2'd0;
    tick();
    cmd_valid = 1'b0;
    n_total++;
    if (dut_vec !== exp_vec() || cmd_err !== 1'b1 || set_broken !== 3'b000)
      $display("FAIL force_break_rejected: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_saturation();
    int irq_seen;
    irq_seen = 0;
    do_reset();
    err_det = 1'b1; err_corr = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (irq === 1'b1) irq_seen++;
      n_total++;
      if (dut_vec !== exp_vec())
        $display("FAIL saturation_step%0d: got %h expected %h", k, dut_vec, exp_vec());
      else n_pass++;
    end
    err_det = 1'b0; err_corr = 1'b0;
    n_total++;
    if (irq_seen !== 1 || err_cnt !== 4'd15 || corr_cnt !== 4'd15)
      $display("FAIL saturation_summary: irqs %0d err %0d corr %0d required 1/15/15", irq_seen, err_cnt, corr_cnt);
    else n_pass++;
  endtask

  task automatic test_clear_with_error();
    do_reset();
    err_det = 1'b1; err_corr = 1'b1;
    repeat (6) tick();
    cmd_valid = 1'b1; cmd_op = 2'd2;
    tick();
    cmd_valid = 1'b0;
    n_total++;
    if (dut_vec !== exp_vec() || err_cnt !== 4'd0 || corr_cnt !== 4'd0)
      $display("FAIL clear_same_cycle: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_total++;
      if (dut_vec !== exp_vec())
        $display("FAIL clear_rearm_step%0d: got %h expected %h", k, dut_vec, exp_vec());
      else n_pass++;
    end
    err_det = 1'b0; err_corr = 1'b0;
  endtask

  task automatic test_reset_mid_command();
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_rep = 2'd1;
    tick();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (dut_vec !== c_reset_vec)
      $display("FAIL reset_mid_command: got %h expected %h", dut_vec, c_reset_vec);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (cmd_done !== 1'b0 || set_broken !== 3'b000 || dut_vec !== c_reset_vec)
      $display("FAIL reset_mid_command_hold: got %h expected %h", dut_vec, c_reset_vec);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int k = 0; k < 50; k++) begin
        if ($urandom_range(0, 29) == 0) is_broken = is_broken | 3'(1 << $urandom_range(0, 2));
        err_det  = ($urandom_range(0, 3) == 0);
        err_corr = err_det ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
        cmd_valid = ($urandom_range(0, 2) == 0);
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_rep   = 2'($urandom_range(0, 3));
        tick();
        n_total++;
        if (dut_vec !== exp_vec())
          $display("FAIL random_seg%0d_cyc%0d: got %h expected %h", seg, k, dut_vec, exp_vec());
        else n_pass++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    c_reset_vec = {2'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    model_reset();
    test_reset();
    test_single_break();
    test_uncorrectable();
    test_force_break();
    test_saturation();
    test_clear_with_error();
    test_reset_mid_command();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
